// File: rtl/vga_fade_core_if.sv
// Slot register bus shared by the video-slot cores: select, write strobe,
// word address and write data.
interface vga_fade_core_if;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  modport master (output cs, write, addr, wr_data);
  modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/vga_fade_core.sv
// vga_fade_core: scales each colour channel of the pixel stream by a
// frame-synchronous brightness level (0..16) and sequences fade-out/fade-in
// one level step every N frames, with optional auto-loop.
// Optional feature macro: VGA_FADE_TINT_EN (fade towards a tint colour
// instead of black).
module vga_fade_core #(
  parameter int unsigned CD = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  vga_fade_core_if.slave  bus,
  input  logic [CD-1:0]   si_rgb,
  output logic [CD-1:0]   so_rgb
);

  localparam int unsigned CW = CD / 3;
  localparam int unsigned PW = CW + 5;

  typedef enum logic [1:0] {
    ST_ON,
    ST_FADE_OUT,
    ST_DARK,
    ST_FADE_IN
  } state_t;

  state_t        state;
  logic [4:0]    level;
  logic [7:0]    cnt;
  logic [7:0]    step;
  logic [7:0]    hold;
  logic          bypass;
  logic          auto_en;
  logic          origin_prev;
`ifdef VGA_FADE_TINT_EN
  logic [CD-1:0] tint;
`endif

  logic          at_origin;
  logic          tick;
  logic          reg_wr;
  logic          ctrl_wr;
  logic          cmd_out;
  logic          cmd_in;
  logic [8:0]    cnt_inc;
  logic [8:0]    step_eff;
  logic [8:0]    hold_eff;
  logic [CD-1:0] scaled;
  logic          unused_bus;

  // Frame tick on the first cycle the counters sit at the origin, plus write decode.
  assign at_origin  = (x == 11'd0) && (y == 11'd0);
  assign tick       = at_origin && !origin_prev;
  assign reg_wr     = bus.cs && bus.write;
  assign ctrl_wr    = reg_wr && (bus.addr[1:0] == 2'b00);
  assign cmd_out    = ctrl_wr && bus.wr_data[1];
  assign cmd_in     = ctrl_wr && bus.wr_data[2];
  assign cnt_inc    = {1'b0, cnt} + 9'd1;
  assign step_eff   = (step == 8'd0) ? 9'd1 : {1'b0, step};
  assign hold_eff   = (hold == 8'd0) ? 9'd1 : {1'b0, hold};
  assign unused_bus = ^{bus.addr[13:2], bus.wr_data};

  // Per-channel blend: c*level (+ tint*(16-level)) then drop the 4 fraction bits.
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [PW-1:0] prod;
`ifdef VGA_FADE_TINT_EN
    assign prod = PW'(si_rgb[g*CW +: CW]) * PW'(level)
                + PW'(tint[g*CW +: CW]) * PW'(5'd16 - level);
`else
    assign prod = PW'(si_rgb[g*CW +: CW]) * PW'(level);
`endif
    assign scaled[g*CW +: CW] = CW'(prod >> 4);
  end

  // Zero-latency pixel path.
  assign so_rgb = bypass ? si_rgb : scaled;

  // Register file, frame-tick edge flag and fade sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_ON;
      level       <= 5'd16;
      cnt         <= 8'd0;
      step        <= 8'd4;
      hold        <= 8'd60;
      bypass      <= 1'b0;
      auto_en     <= 1'b0;
      origin_prev <= 1'b0;
`ifdef VGA_FADE_TINT_EN
      tint        <= '0;
`endif
    end else begin
      origin_prev <= at_origin;

      if (ctrl_wr) begin
        bypass  <= bus.wr_data[0];
        auto_en <= bus.wr_data[3];
      end
      if (reg_wr && (bus.addr[1:0] == 2'b01)) step <= bus.wr_data[7:0];
      if (reg_wr && (bus.addr[1:0] == 2'b10)) hold <= bus.wr_data[7:0];
`ifdef VGA_FADE_TINT_EN
      if (reg_wr && (bus.addr[1:0] == 2'b11)) tint <= bus.wr_data[CD-1:0];
`endif

      if (cmd_out) begin
        state <= ST_FADE_OUT;
        cnt   <= 8'd0;
      end else if (cmd_in) begin
        state <= ST_FADE_IN;
        cnt   <= 8'd0;
      end else if (tick) begin
        case (state)
          ST_FADE_OUT: begin
            if (level == 5'd0) begin
              state <= ST_DARK;
              cnt   <= 8'd0;
            end else if (cnt_inc >= step_eff) begin
              level <= level - 5'd1;
              cnt   <= 8'd0;
              if (level == 5'd1) state <= ST_DARK;
            end else begin
              cnt <= cnt_inc[7:0];
            end
          end
          ST_FADE_IN: begin
            if (level >= 5'd16) begin
              state <= ST_ON;
              cnt   <= 8'd0;
            end else if (cnt_inc >= step_eff) begin
              level <= level + 5'd1;
              cnt   <= 8'd0;
              if (level == 5'd15) state <= ST_ON;
            end else begin
              cnt <= cnt_inc[7:0];
            end
          end
          ST_ON: begin
            if (auto_en) begin
              if (cnt_inc >= hold_eff) begin
                state <= ST_FADE_OUT;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt_inc[7:0];
              end
            end
          end
          default: begin
            if (auto_en) begin
              if (cnt_inc >= hold_eff) begin
                state <= ST_FADE_IN;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt_inc[7:0];
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_fade_core.sv
// Directed bench for vga_fade_core: reset, fades, reversal, step/hold
// changes, command/tick collisions, auto loop, bypass, tint and async reset.
module tb_vga_fade_core;

  logic        clk;
  logic        reset_n;
  logic [10:0] x;
  logic [10:0] y;
  logic [11:0] si_rgb;
  logic [11:0] so_rgb;
  int          tests;
  int          fails;

  vga_fade_core_if bus ();

  vga_fade_core #(.CD(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .bus     (bus),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One register write cycle.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = {12'd0, a}; bus.wr_data = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  // n frames: one cycle at the origin, one cycle elsewhere.
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk); #1; x = 11'd0; y = 11'd0;
      @(posedge clk); #1; x = 11'd5; y = 11'd5;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; x = 11'd5; y = 11'd5; si_rgb = 12'hABC;
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    #12;
    tests++; if (so_rgb !== 12'hABC) begin fails++; $display("FAIL rst_hold so_rgb=%h exp=%h", so_rgb, 12'hABC); end
    @(negedge clk); reset_n = 1'b1;
    ticks(3);
    tests++; if (so_rgb !== 12'hABC) begin fails++; $display("FAIL rst_idle so_rgb=%h exp=%h", so_rgb, 12'hABC); end
  endtask

  task automatic test_fade_out_in();
    si_rgb = 12'hFFF;
    wr(2'b01, 32'd1);
    wr(2'b00, 32'h2);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL fo_cmd so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(1);
    tests++; if (so_rgb !== 12'hEEE) begin fails++; $display("FAIL fo_1 so_rgb=%h exp=%h", so_rgb, 12'hEEE); end
    ticks(7);
    tests++; if (so_rgb !== 12'h777) begin fails++; $display("FAIL fo_8 so_rgb=%h exp=%h", so_rgb, 12'h777); end
    ticks(8);
    tests++; if (so_rgb !== 12'h000) begin fails++; $display("FAIL fo_16 so_rgb=%h exp=%h", so_rgb, 12'h000); end
    ticks(3);
    tests++; if (so_rgb !== 12'h000) begin fails++; $display("FAIL dark_stay so_rgb=%h exp=%h", so_rgb, 12'h000); end
    wr(2'b00, 32'h4);
    ticks(8);
    si_rgb = 12'hABC; #1;
    tests++; if (so_rgb !== 12'h556) begin fails++; $display("FAIL fi_8 so_rgb=%h exp=%h", so_rgb, 12'h556); end
    si_rgb = 12'hFFF;
    ticks(8);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL fi_16 so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(2);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL on_stay so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
  endtask

  task automatic test_reverse();
    wr(2'b01, 32'd2);
    wr(2'b00, 32'h2);
    ticks(6);
    tests++; if (so_rgb !== 12'hCCC) begin fails++; $display("FAIL rev_l13 so_rgb=%h exp=%h", so_rgb, 12'hCCC); end
    wr(2'b00, 32'h4);
    ticks(1);
    tests++; if (so_rgb !== 12'hCCC) begin fails++; $display("FAIL rev_t1 so_rgb=%h exp=%h", so_rgb, 12'hCCC); end
    ticks(1);
    tests++; if (so_rgb !== 12'hDDD) begin fails++; $display("FAIL rev_t2 so_rgb=%h exp=%h", so_rgb, 12'hDDD); end
    ticks(4);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL rev_t6 so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(2);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL rev_on so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
  endtask

  task automatic test_step_change();
    wr(2'b01, 32'd4);
    wr(2'b00, 32'h2);
    ticks(3);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL stp_cnt3 so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    wr(2'b01, 32'd2);
    ticks(1);
    tests++; if (so_rgb !== 12'hEEE) begin fails++; $display("FAIL stp_lower so_rgb=%h exp=%h", so_rgb, 12'hEEE); end
    wr(2'b01, 32'd0);
    ticks(1);
    tests++; if (so_rgb !== 12'hDDD) begin fails++; $display("FAIL stp_zero1 so_rgb=%h exp=%h", so_rgb, 12'hDDD); end
    ticks(1);
    tests++; if (so_rgb !== 12'hCCC) begin fails++; $display("FAIL stp_zero2 so_rgb=%h exp=%h", so_rgb, 12'hCCC); end
    wr(2'b00, 32'h4);
    ticks(3);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL stp_back so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
  endtask

  task automatic test_commands();
    wr(2'b01, 32'd1);
    wr(2'b00, 32'h6);
    @(posedge clk); #1; x = 11'd0; y = 11'd0;
    repeat (10) @(posedge clk);
    #1; x = 11'd5; y = 11'd5;
    tests++; if (so_rgb !== 12'hEEE) begin fails++; $display("FAIL held_origin so_rgb=%h exp=%h", so_rgb, 12'hEEE); end
    // fade-out command written in the tick cycle: tick must not count
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd0; bus.wr_data = 32'h2;
    x = 11'd0; y = 11'd0;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0; x = 11'd5; y = 11'd5;
    tests++; if (so_rgb !== 12'hEEE) begin fails++; $display("FAIL cmd_tick so_rgb=%h exp=%h", so_rgb, 12'hEEE); end
    ticks(1);
    tests++; if (so_rgb !== 12'hDDD) begin fails++; $display("FAIL cmd_after so_rgb=%h exp=%h", so_rgb, 12'hDDD); end
    wr(2'b00, 32'h4);
    ticks(2);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL fi_return so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    wr(2'b00, 32'h4);
    ticks(2);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL fi_at_target so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
  endtask

  task automatic test_auto();
    wr(2'b10, 32'd3);
    wr(2'b01, 32'd1);
    wr(2'b00, 32'h8);
    ticks(3);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL auto_t3 so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(1);
    tests++; if (so_rgb !== 12'hEEE) begin fails++; $display("FAIL auto_t4 so_rgb=%h exp=%h", so_rgb, 12'hEEE); end
    ticks(15);
    tests++; if (so_rgb !== 12'h000) begin fails++; $display("FAIL auto_t19 so_rgb=%h exp=%h", so_rgb, 12'h000); end
    ticks(3);
    tests++; if (so_rgb !== 12'h000) begin fails++; $display("FAIL auto_t22 so_rgb=%h exp=%h", so_rgb, 12'h000); end
    ticks(2);
    tests++; if (so_rgb !== 12'h111) begin fails++; $display("FAIL auto_t24 so_rgb=%h exp=%h", so_rgb, 12'h111); end
    ticks(14);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL auto_t38 so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(3);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL auto_t41 so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(1);
    tests++; if (so_rgb !== 12'hEEE) begin fails++; $display("FAIL auto_t42 so_rgb=%h exp=%h", so_rgb, 12'hEEE); end
    si_rgb = 12'hABC;
    wr(2'b00, 32'h9);
    tests++; if (so_rgb !== 12'hABC) begin fails++; $display("FAIL bypass so_rgb=%h exp=%h", so_rgb, 12'hABC); end
    si_rgb = 12'hFFF;
    wr(2'b00, 32'h4);
    ticks(1);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL auto_exit so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    ticks(4);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL auto_off so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
  endtask

  task automatic test_tint();
    logic [11:0] exp_mid;
`ifdef VGA_FADE_TINT_EN
    exp_mid = 12'h707;
`else
    exp_mid = 12'h007;
`endif
    wr(2'b11, 32'hF00);
    si_rgb = 12'h00F; #1;
    tests++; if (so_rgb !== 12'h00F) begin fails++; $display("FAIL tint_l16 so_rgb=%h exp=%h", so_rgb, 12'h00F); end
    wr(2'b00, 32'h2);
    ticks(8);
    tests++; if (so_rgb !== exp_mid) begin fails++; $display("FAIL tint_l8 so_rgb=%h exp=%h", so_rgb, exp_mid); end
    wr(2'b00, 32'h4);
    ticks(8);
    si_rgb = 12'hFFF;
  endtask

  task automatic test_reset_mid_fade();
    wr(2'b00, 32'h2);
    ticks(4);
    tests++; if (so_rgb !== 12'hBBB) begin fails++; $display("FAIL mid_l12 so_rgb=%h exp=%h", so_rgb, 12'hBBB); end
    #2; reset_n = 1'b0;
    #1;
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL async_rst so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
    @(negedge clk); reset_n = 1'b1;
    ticks(3);
    tests++; if (so_rgb !== 12'hFFF) begin fails++; $display("FAIL post_rst so_rgb=%h exp=%h", so_rgb, 12'hFFF); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fade_out_in();
    test_reverse();
    test_step_change();
    test_commands();
    test_auto();
    test_tint();
    test_reset_mid_fade();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
